// File: rtl/fifo_pkg.sv
// fifo_pkg: read-mode constants and threshold legality check shared by the FIFO files.
package fifo_pkg;
  localparam int MODE_STD  = 0;
  localparam int MODE_FWFT = 1;
  function automatic bit levels_ok(input int depth, input int af, input int ae);
    return (ae < af) && (af <= (1 << depth));
  endfunction
endpackage

// File: rtl/fifo_sync_ram.sv
// fifo_sync_ram: 2^DEPTH x WIDTH storage, synchronous write, asynchronous read.
module fifo_sync_ram #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 7
) (
  input  logic             clk,
  input  logic             we,
  input  logic [DEPTH-1:0] waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [DEPTH-1:0] raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [2**DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/fifo_sync_buffer.sv
// fifo_sync_buffer: single-clock FIFO with status flags, occupancy count, error strobes and optional FWFT read.
module fifo_sync_buffer
  import fifo_pkg::*;
#(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 7,
  parameter int AF_LEVEL = 2**DEPTH - 4,
  parameter int AE_LEVEL = 4,
  parameter int FWFT     = MODE_STD
) (
  input  logic             clk_in,
  input  logic             reset,
  input  logic             flush,
  input  logic             insert,
  input  logic [WIDTH-1:0] data_in,
  input  logic             remove,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic [DEPTH:0]   count,
  output logic             overflow,
  output logic             underflow
);
  localparam logic [DEPTH:0] AF_CNT = (DEPTH+1)'(AF_LEVEL);
  localparam logic [DEPTH:0] AE_CNT = (DEPTH+1)'(AE_LEVEL);
  if (!levels_ok(DEPTH, AF_LEVEL, AE_LEVEL)) begin : g_bad_levels
    $error("fifo_sync_buffer: thresholds must satisfy AE_LEVEL < AF_LEVEL <= 2^DEPTH");
  end
  logic [DEPTH:0]   wr_ptr, rd_ptr, wr_ptr_nx, rd_ptr_nx, count_nx;
  logic [DEPTH-1:0] rd_addr;
  logic [WIDTH-1:0] rdata, data_d;
  logic             wr_ok, rd_ok, bypass, data_en;
  always_comb begin
    rd_ok     = remove && !empty;
    wr_ok     = insert && (!full || rd_ok);
    wr_ptr_nx = wr_ptr + (DEPTH+1)'(wr_ok);
    rd_ptr_nx = rd_ptr + (DEPTH+1)'(rd_ok);
    count_nx  = wr_ptr_nx - rd_ptr_nx;
    // FWFT looks ahead at the post-edge head; a word written this cycle that becomes the head is not in storage yet
    rd_addr   = (FWFT == MODE_FWFT) ? rd_ptr_nx[DEPTH-1:0] : rd_ptr[DEPTH-1:0];
    bypass    = wr_ok && (wr_ptr[DEPTH-1:0] == rd_ptr_nx[DEPTH-1:0]);
    data_d    = (FWFT == MODE_FWFT && bypass) ? data_in : rdata;
    data_en   = (FWFT == MODE_FWFT) ? (count_nx != '0) : rd_ok;
  end
  fifo_sync_ram #(.WIDTH(WIDTH), .DEPTH(DEPTH)) u_ram (
    .clk  (clk_in),
    .we   (wr_ok && !flush && reset),
    .waddr(wr_ptr[DEPTH-1:0]),
    .wdata(data_in),
    .raddr(rd_addr),
    .rdata(rdata)
  );
  always_ff @(posedge clk_in or negedge reset)
    if (!reset) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else if (flush) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      data_out     <= '0;
      empty        <= 1'b1;
      almost_empty <= 1'b1;
      full         <= 1'b0;
      almost_full  <= 1'b0;
      overflow     <= 1'b0;
      underflow    <= 1'b0;
    end else begin
      wr_ptr       <= wr_ptr_nx;
      rd_ptr       <= rd_ptr_nx;
      count        <= count_nx;
      empty        <= wr_ptr_nx == rd_ptr_nx;
      full         <= (wr_ptr_nx[DEPTH-1:0] == rd_ptr_nx[DEPTH-1:0]) && (wr_ptr_nx[DEPTH] != rd_ptr_nx[DEPTH]);
      almost_full  <= count_nx >= AF_CNT;
      almost_empty <= count_nx <= AE_CNT;
      overflow     <= insert && !wr_ok;
      underflow    <= remove && !rd_ok;
      if (data_en) data_out <= data_d;
    end
endmodule

// File: tb/tb_fifo_sync_buffer.sv
// tb_fifo_sync_buffer: queue-model checks of standard and FWFT instances driven by shared directed stimulus.
module tb_fifo_sync_buffer;
  logic        clk = 1'b0, rst_n = 1'b0, flush = 1'b0, insert = 1'b0, remove = 1'b0, run = 1'b0;
  logic [31:0] data_in = '0;
  logic [31:0] d0_out, d1_out;
  logic [3:0]  d0_cnt, d1_cnt;
  logic        d0_full, d0_empty, d0_af, d0_ae, d0_ov, d0_un;
  logic        d1_full, d1_empty, d1_af, d1_ae, d1_ov, d1_un;
  int          checks = 0, errors = 0;
  logic [31:0] q[$];
  logic [31:0] m_do0 = '0, m_do1 = '0;
  logic        m_ov = 1'b0, m_un = 1'b0;
  always #5 clk = ~clk;
  fifo_sync_buffer #(.WIDTH(32), .DEPTH(3), .AF_LEVEL(4), .AE_LEVEL(2), .FWFT(0)) d0 (
    .clk_in(clk), .reset(rst_n), .flush(flush), .insert(insert), .data_in(data_in), .remove(remove),
    .data_out(d0_out), .full(d0_full), .empty(d0_empty), .almost_full(d0_af), .almost_empty(d0_ae),
    .count(d0_cnt), .overflow(d0_ov), .underflow(d0_un));
  fifo_sync_buffer #(.WIDTH(32), .DEPTH(3), .AF_LEVEL(4), .AE_LEVEL(2), .FWFT(1)) d1 (
    .clk_in(clk), .reset(rst_n), .flush(flush), .insert(insert), .data_in(data_in), .remove(remove),
    .data_out(d1_out), .full(d1_full), .empty(d1_empty), .almost_full(d1_af), .almost_empty(d1_ae),
    .count(d1_cnt), .overflow(d1_ov), .underflow(d1_un));
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask
  task automatic model_reset();
    q.delete();
    m_do0 = '0;
    m_do1 = '0;
    m_ov  = 1'b0;
    m_un  = 1'b0;
  endtask
  task automatic model(input logic i, input logic [31:0] d, input logic r, input logic f);
    logic rd, wr;
    if (f) begin
      model_reset();
    end else begin
      rd   = r && q.size() > 0;
      wr   = i && (q.size() < 8 || rd);
      m_un = r && !rd;
      m_ov = i && !wr;
      if (rd) m_do0 = q.pop_front();
      if (wr) q.push_back(d);
      if (q.size() > 0) m_do1 = q[0];
    end
  endtask
  task automatic step(input logic i, input logic [31:0] d, input logic r, input logic f);
    insert = i; data_in = d; remove = r; flush = f;
    @(posedge clk);
    model(i, d, r, f);
    @(negedge clk);
  endtask
  always @(negedge clk) if (run && rst_n) begin
    chk("d0_data_out", d0_out, m_do0);
    chk("d1_data_out", d1_out, m_do1);
    chk("d0_count", 32'(d0_cnt), q.size());
    chk("d1_count", 32'(d1_cnt), q.size());
    chk("d0_full", 32'(d0_full), 32'(q.size() == 8));
    chk("d1_full", 32'(d1_full), 32'(q.size() == 8));
    chk("d0_empty", 32'(d0_empty), 32'(q.size() == 0));
    chk("d1_empty", 32'(d1_empty), 32'(q.size() == 0));
    chk("d0_almost_full", 32'(d0_af), 32'(q.size() >= 4));
    chk("d1_almost_full", 32'(d1_af), 32'(q.size() >= 4));
    chk("d0_almost_empty", 32'(d0_ae), 32'(q.size() <= 2));
    chk("d1_almost_empty", 32'(d1_ae), 32'(q.size() <= 2));
    chk("d0_overflow", 32'(d0_ov), 32'(m_ov));
    chk("d1_overflow", 32'(d1_ov), 32'(m_ov));
    chk("d0_underflow", 32'(d0_un), 32'(m_un));
    chk("d1_underflow", 32'(d1_un), 32'(m_un));
  end
  task automatic chk_reset_vals(input string tag);
    chk({tag, "_d0_data_out"}, d0_out, 32'h0);
    chk({tag, "_d1_data_out"}, d1_out, 32'h0);
    chk({tag, "_count"}, 32'(d0_cnt), 32'd0);
    chk({tag, "_empty"}, 32'(d0_empty && d1_empty), 32'd1);
    chk({tag, "_almost_empty"}, 32'(d0_ae && d1_ae), 32'd1);
    chk({tag, "_full_af_strobes"}, 32'({d0_full, d0_af, d0_ov, d0_un, d1_full, d1_af, d1_ov, d1_un}), 32'd0);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk_reset_vals("reset");
    rst_n = 1'b1;
    run = 1'b1;
    for (int i = 1; i <= 8; i++) begin
      step(1'b1, 32'(i * 'h11), 1'b0, 1'b0);
      if (i == 3) chk("af_at_3", 32'(d0_af), 32'd0);
      if (i == 4) chk("af_at_4", 32'(d0_af), 32'd1);
    end
    chk("fill_count", 32'(d0_cnt), 32'd8);
    chk("fill_full", 32'(d0_full), 32'd1);
    chk("fill_fwft_head", d1_out, 32'h11);
    step(1'b1, 32'h99, 1'b0, 1'b0);
    chk("overflow_pulse", 32'(d0_ov), 32'd1);
    chk("overflow_count", 32'(d0_cnt), 32'd8);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    chk("overflow_clears", 32'(d0_ov), 32'd0);
    step(1'b1, 32'h99, 1'b1, 1'b0);
    chk("full_swap_dout", d0_out, 32'h11);
    chk("full_swap_fwft", d1_out, 32'h22);
    chk("full_swap_count", 32'(d0_cnt), 32'd8);
    chk("full_swap_no_ov", 32'(d0_ov), 32'd0);
    for (int i = 0; i < 16; i++) step(1'b1, 32'hA0 + 32'(i), 1'b1, 1'b0);
    chk("wrap_dout", d0_out, 32'hA7);
    for (int i = 0; i < 8; i++) step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("drain_last", d0_out, 32'hAF);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("underflow_pulse", 32'(d0_un), 32'd1);
    chk("underflow_hold", d0_out, 32'hAF);
    step(1'b1, 32'hA5, 1'b1, 1'b0);
    chk("ins_rem_empty_count", 32'(d0_cnt), 32'd1);
    chk("ins_rem_empty_un", 32'(d1_un), 32'd1);
    chk("ins_rem_empty_fwft", d1_out, 32'hA5);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("pop_a5_std", d0_out, 32'hA5);
    step(1'b1, 32'hDEAD, 1'b0, 1'b0);
    chk("fwft_dead", d1_out, 32'hDEAD);
    chk("fwft_dead_empty", 32'(d1_empty), 32'd0);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("fwft_hold_dead", d1_out, 32'hDEAD);
    chk("fwft_now_empty", 32'(d1_empty), 32'd1);
    for (int i = 0; i < 5; i++) step(1'b1, 32'h30 + 32'(i), 1'b0, 1'b0);
    chk("pre_flush_count", 32'(d0_cnt), 32'd5);
    step(1'b1, 32'h55, 1'b1, 1'b1);
    chk_reset_vals("flush");
    step(1'b1, 32'h42, 1'b0, 1'b0);
    chk("post_flush_fwft", d1_out, 32'h42);
    step(1'b0, 32'h0, 1'b1, 1'b0);
    chk("post_flush_std", d0_out, 32'h42);
    for (int i = 0; i < 3; i++) step(1'b1, 32'h60 + 32'(i), 1'b1, 1'b0);
    insert = 1'b1; data_in = 32'h70;
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    chk_reset_vals("async_reset");
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b1, 32'h77, 1'b0, 1'b0);
    chk("resume_count", 32'(d0_cnt), 32'd1);
    chk("resume_fwft", d1_out, 32'h77);
    step(1'b0, 32'h0, 1'b0, 1'b0);
    run = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_sync_buffer.md
# fifo_sync_buffer

Single-clock, parametrised FIFO: the next-generation buffer for producer/consumer paths that share one clock. It adds full/empty and programmable almost-full/almost-empty flags, an occupancy count, overflow/underflow strobes and a first-word-fall-through (FWFT) read mode. Pointer arithmetic and status flags are handled internally, so callers no longer maintain external read/write pointers.

## Interface
- WIDTH, 32, data word width in bits
- DEPTH, 7, log2 of entry count; capacity = 2^DEPTH entries
- AF_LEVEL, 2^DEPTH-4, almost_full asserts when count >= AF_LEVEL
- AE_LEVEL, 4, almost_empty asserts when count <= AE_LEVEL
- FWFT, 0, 0 = registered read on remove; 1 = first-word-fall-through
- clk_in  input  1  sole clock, all state on rising edge
- reset  input  1  asynchronous, active-low
- flush  input  1  synchronous clear of pointers, count and data_out
- insert  input  1  write request
- data_in  input  WIDTH  write data
- remove  input  1  read/pop request
- data_out  output  WIDTH  read data
- full, empty  output  1 each  status flags
- almost_full, almost_empty  output  1 each  threshold flags
- count  output  DEPTH+1  occupancy, 0..2^DEPTH
- overflow, underflow  output  1 each  one-cycle error strobes

## Operation
- Pointers are DEPTH+1 bits: the low DEPTH bits address storage, the MSB is the wrap bit. Empty when pointers are equal; full when the low bits are equal and the MSBs differ.
- Priority, highest first: reset, flush, insert/remove.
- Insert is accepted when !full, or when full with an accepted remove in the same cycle. Otherwise it is dropped, overflow pulses for 1 cycle, and storage/pointers are unchanged.
- Remove is accepted when !empty. Otherwise underflow pulses for 1 cycle and data_out holds. Insert+remove on empty: insert accepted, remove rejected (underflow=1).
- count: +1 on accepted insert only, −1 on accepted remove only, unchanged when both are accepted.
- Flags are registered and derived from next-state count, so they are always consistent with count in the same cycle.
- FWFT=0: on an accepted remove, data_out loads the head word; otherwise data_out holds.
- FWFT=1: whenever !empty, data_out presents the head word. An accepted remove pops it, and the next word (if any) appears the following cycle. When the FIFO becomes empty, data_out holds the last value.
- Flush: pointers, count, data_out, overflow and underflow go to 0; empty=1, almost_empty=1. Insert/remove in the same cycle are ignored with no strobes. Storage contents are not cleared.
- Reset (asynchronous, any time, including mid-burst): same state as flush, applied immediately.

## Timing
- Reset values: data_out=0, count=0, empty=1, almost_empty=1, full=0, almost_full=0, overflow=0, underflow=0.
- Insert into an empty FIFO at edge N: empty=0, count=1 after edge N. With FWFT=1, data_out equals that word after edge N.
- FWFT=0 read latency is 1 cycle: data_out is valid after the edge that accepts remove.
- Wrap-around is seamless: pointer low bits roll from 2^DEPTH−1 to 0 with the MSB toggled.
- Throughput is 1 insert + 1 remove per cycle sustained.
- No combinational path from inputs to outputs.

## Structure
- Shared package fifo_pkg holds the FWFT mode constants (MODE_STD=0, MODE_FWFT=1) and the threshold-legality checks (AE_LEVEL < AF_LEVEL <= 2^DEPTH).
- Sub-module fifo_sync_ram: 2^DEPTH×WIDTH array with synchronous write and asynchronous read by address. The top level holds pointers, count, flags and the output register.

## Test plan
- DEPTH=3, FWFT=0: insert 0x11..0x88 (8 words) -> full=1, count=8, almost_full=1 from count 4; a 9th insert -> overflow pulses 1 cycle, count stays 8.
- Full FIFO, insert 0x99 + remove in the same cycle -> data_out=0x11, count=8, no overflow; continue 16 cycles to exercise pointer wrap, with data order preserved.
- Empty FIFO, remove -> underflow pulses, data_out holds; insert 0xA5 + remove together -> count=1, underflow=1.
- FWFT=1: insert 0xDEAD at edge N -> data_out=0xDEAD, empty=0 after N; remove -> empty=1, data_out holds 0xDEAD.
- Count=5, flush with insert asserted -> count=0, empty=1, data_out=0, no strobes; the next insert of 0x42 reads back 0x42.
- Reset asserted mid-burst between clock edges -> all outputs at reset values immediately; normal operation resumes on the first edge after deassertion.
